pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register that generalises the fixed ID/EX register into a reusable ready/valid stage with any payload width. It has a separately resettable control field, a synchronous flush that inserts bubbles, and an optional two-entry skid buffer that registers the backpressure path. It sits between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). The hazard unit drives `flush_i`, and the downstream stage's stall logic drives `out_ready_i`.

## Interface
- `DATA_W`, 96: width of the data payload (PC, operands, immediate, register addresses); cleared to 0 on reset/flush.
- `CTRL_W`, 16: width of the control payload (branch, mem_read/write, reg_write, alu_op, ...).
- `CTRL_BUBBLE`, `'0`: value that `out_ctrl_o` carries for a bubble; the instantiator encodes the no-side-effect control word here.
- `SKID`, 1: 0 selects a single-entry stage with a combinational ready path; 1 selects a two-entry stage with a registered `in_ready_o`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush_i`  in  1  synchronous kill of all held entries.
- `in_valid_i`  in  1  upstream offers an entry.
- `in_ready_o`  out  1  stage accepts an entry this cycle.
- `in_ctrl_i`  in  CTRL_W  incoming control word.
- `in_data_i`  in  DATA_W  incoming data word.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  downstream consumes the head entry.
- `out_ctrl_o`  out  CTRL_W  head control; equals CTRL_BUBBLE whenever `out_valid_o`=0.
- `out_data_o`  out  DATA_W  head data.
- `occupancy_o`  out  2  number of entries held (0..2; max 1 when SKID=0).

## Operation
- **Handshakes**
  - in_fire = `in_valid_i` & `in_ready_o`.
  - out_fire = `out_valid_o` & `out_ready_i`.
  - Upstream keeps its payload stable while valid and not accepted.
- **Entries**
  - Main entry drives the outputs.
  - Skid entry exists only when SKID=1.
- **SKID=0**
  - `in_ready_o` = !`flush_i` & (!main_valid | `out_ready_i`).
  - On in_fire, main loads the input.
  - On out_fire without in_fire, main_valid clears and main ctrl loads CTRL_BUBBLE.
- **SKID=1**
  - `in_ready_o` = !skid_valid & !`flush_i`; skid_valid is a register.
  - If out_fire or !main_valid, main loads the skid entry if skid_valid, else the input if in_fire, else becomes a bubble. skid_valid clears when the skid entry moves.
  - If main_valid & !out_fire & in_fire, skid loads the input.
  - Order is always preserved: the skid entry is older than any new input.
- **Flush**
  - Clears main_valid and skid_valid.
  - Both ctrl registers load CTRL_BUBBLE; both data registers load 0.
  - `in_ready_o` is 0 in the flush cycle, so no input is lost.
  - An out_fire in the flush cycle completes normally: downstream keeps that entry, and the flush kills only what remains.
- **Reset**
  - Identical to flush. Reset has priority over flush; flush has priority over all transfers.
- **Occupancy**
  - `occupancy_o` = main_valid + skid_valid.

## Timing
- **Reset values**: `out_valid_o`=0, `out_ctrl_o`=CTRL_BUBBLE, `out_data_o`=0, `occupancy_o`=0. `in_ready_o`=1 in the first cycle after reset deasserts (SKID=1, or SKID=0 with main empty).
- **Latency**: 1 cycle from in_fire to `out_valid_o` when the stage is empty.
- **Throughput**: 1 entry per cycle with `out_ready_i` held high, for both SKID values.
- **SKID=1 fill**: with `out_ready_i` low, the 2nd accepted entry fills skid; `in_ready_o` drops the next cycle; no 3rd entry is accepted.
- **SKID=1 drain**: `out_ready_i` high with skid full means the skid entry reaches main in 1 cycle, and `in_ready_o` rises the following cycle.
- **Combinational paths**: with SKID=1, no path exists from `out_ready_i` to `in_ready_o`. With SKID=0, the path exists and is documented to integrators.
- **Mid-operation reset or flush**: no partial state survives. The next cycle looks like post-reset.

## Structure
- Shared package `pipeline_pkg` holds:
  - per-stage control-word struct typedefs (`id_ex_ctrl_t`, `ex_mem_ctrl_t`, ...);
  - their bubble constants (e.g. ID/EX bubble uses `ALU_ADD` with all enables 0);
  - per-stage data widths.
- The two entries are identical, so a sub-module `pipe_slot` is natural: one valid bit, a ctrl register with bubble load, and a data register with clear. It is instantiated once for SKID=0 and twice for SKID=1.
- No FSM beyond the two valid bits (encoded states EMPTY, ONE, FULL).

## Test plan
- **Reset with upstream driving**: reset with `in_valid_i`=1 and ctrl=16'hBEEF -> `out_valid_o`=0, `out_ctrl_o`=CTRL_BUBBLE, `occupancy_o`=0 during and after reset; first entry appears 1 cycle after reset deasserts.
- **Streaming**: 8 entries (data 1..8), `out_ready_i`=1, SKID=0 and SKID=1 -> outputs 1..8 on 8 consecutive cycles, each 1 cycle after input.
- **Backpressure (SKID=1)**: `out_ready_i`=0 with entries A, B, C offered -> A in main, B in skid, `in_ready_o`=0, C held, `occupancy_o`=2. Releasing `out_ready_i` -> A, B, C delivered in order with no duplicates.
- **Flush with full stage (SKID=1)**: `flush_i` with 2 entries held and `out_ready_i`=0 -> next cycle `out_valid_o`=0, ctrl=CTRL_BUBBLE, data=0, `occupancy_o`=0; `in_ready_o`=0 in the flush cycle.
- **Flush concurrent with out_fire**: flush in the same cycle as out_fire of entry X -> X counted as delivered once, the skid entry is killed, and no input is accepted that cycle.
- **Randomised stall on `out_ready_i`**, 1000 entries, both SKID values -> scoreboard matches in-order, with `out_ctrl_o`=CTRL_BUBBLE on every cycle where `out_valid_o`=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: per-stage control words, their bubble encodings,
// per-stage data widths and the occupancy encoding used by pipe_stage_reg.
package pipeline_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h1,
    ALU_SUB = 4'h2,
    ALU_AND = 4'h3,
    ALU_OR  = 4'h4,
    ALU_XOR = 4'h5,
    ALU_SLT = 4'h6
  } alu_op_e;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    alu_op_e    alu_op;
    logic [5:0] rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [10:0] rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [13:0] rsvd;
  } mem_wb_ctrl_t;

  // A bubble must not write anything; ALU_ADD keeps the ALU on a harmless op.
  localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
    branch: 1'b0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
    mem_to_reg: 1'b0, alu_src: 1'b0, alu_op: ALU_ADD, rsvd: 6'd0};
  localparam ex_mem_ctrl_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_ctrl_t MEM_WB_BUBBLE = '0;

  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_DATA_W  = 96;
  localparam int EX_MEM_DATA_W = 80;
  localparam int MEM_WB_DATA_W = 40;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    case ({main_v, skid_v})
      2'b00:   return EMPTY;
      2'b11:   return FULL;
      default: return ONE;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle of one pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96
);
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;

  // Stage side.
  modport slave (
    input  flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
  );

  // Environment side (upstream, downstream and hazard unit).
  modport master (
    output flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_slot.sv
// One stage entry: valid bit, control register with bubble load, data register
// with clear. Clear (flush) beats load; bubble only kills valid and control.
module pipe_slot #(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 96,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable ready/valid pipeline stage register with flush and optional skid entry.
// SKID=0 has a combinational out_ready_i -> in_ready_o path; SKID=1 does not.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int                DATA_W      = 96,
  parameter int                CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID        = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_ready, in_fire, out_fire;

  assign in_fire  = bus.in_valid_i & in_ready;
  assign out_fire = main_valid & bus.out_ready_i;

  if (SKID == 1'b0) begin : g_single
    assign in_ready   = !bus.flush_i & (!main_valid | bus.out_ready_i);
    assign skid_valid = 1'b0;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_main (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (bus.flush_i),
      .load_i   (in_fire),
      .bubble_i (out_fire & !in_fire),
      .ctrl_i   (bus.in_ctrl_i),
      .data_i   (bus.in_data_i),
      .valid_o  (main_valid),
      .ctrl_o   (main_ctrl),
      .data_o   (main_data)
    );
  end else begin : g_skid
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              adv;

    // Ready depends only on registered state, so backpressure is cut here.
    assign in_ready = !skid_valid & !bus.flush_i;
    // Main slot is free to take a new entry this cycle.
    assign adv      = out_fire | !main_valid;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_main (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (bus.flush_i),
      .load_i   (adv & (skid_valid | in_fire)),
      .bubble_i (adv & !skid_valid & !in_fire),
      .ctrl_i   (skid_valid ? skid_ctrl : bus.in_ctrl_i),
      .data_i   (skid_valid ? skid_data : bus.in_data_i),
      .valid_o  (main_valid),
      .ctrl_o   (main_ctrl),
      .data_o   (main_data)
    );

    // Skid only catches input while main is stuck; it always drains first.
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(CTRL_BUBBLE)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (bus.flush_i),
      .load_i   (main_valid & !out_fire & in_fire),
      .bubble_i (adv & skid_valid),
      .ctrl_i   (bus.in_ctrl_i),
      .data_i   (bus.in_data_i),
      .valid_o  (skid_valid),
      .ctrl_o   (skid_ctrl),
      .data_o   (skid_data)
    );
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = main_valid;
  assign bus.out_ctrl_o  = main_ctrl;
  assign bus.out_data_o  = main_data;
  assign bus.occupancy_o = 2'(occ_of(main_valid, skid_valid));
endmodule
